// File: rtl/mmu_pkg.sv
// Shared types and helpers for the MMU feeder: default sizes, FSM encoding
// and the lane-to-bit-slice mapping used on the row buses.
package mmu_pkg;

  localparam int unsigned N_DEF  = 4;
  localparam int unsigned DW_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_WT,
    EMIT_WT,
    FEED,
    DRAIN
  } feeder_state_t;

  // Lane 0 is the most significant element of a row.
  function automatic int unsigned lane_lsb(input int unsigned lane,
                                           input int unsigned n,
                                           input int unsigned dw);
    return (n - 1 - lane) * dw;
  endfunction

endpackage

// File: rtl/mmu_skew_line.sv
// DEPTH-stage shift register with zero reset; DEPTH=0 is a plain wire.
module mmu_skew_line #(
  parameter int unsigned DEPTH = 1,
  parameter int unsigned DW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      logic unused_clk;
      assign unused_clk = clk ^ rst_n;
      assign dout = din;
    end else begin : g_shift
      logic [DW-1:0] sr_q [DEPTH];
      logic [DW-1:0] sr_d [DEPTH];

      always_comb begin
        sr_d[0] = din;
        for (int unsigned i = 1; i < DEPTH; i++) begin
          sr_d[i] = sr_q[i-1];
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          sr_q <= '{default: '0};
        end else begin
          sr_q <= sr_d;
        end
      end

      assign dout = sr_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mmu_feeder.sv
// Stream-to-MMU adapter: buffers N weight rows, replays them under the
// control strobe, then feeds data rows through a per-lane diagonal skew.
module mmu_feeder
  import mmu_pkg::*;
#(
  parameter int unsigned N           = N_DEF,
  parameter int unsigned DW          = DW_DEF,
  parameter int unsigned DRAIN_EXTRA = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            s_valid,
  output logic            s_ready,
  input  logic [N*DW-1:0] s_data,
  input  logic            s_wt,
  input  logic            s_last,
  output logic            control,
  output logic [N*DW-1:0] wt_arr,
  output logic [N*DW-1:0] data_arr,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam int unsigned W         = N * DW;
  localparam int unsigned DRAIN_LEN = N - 1 + DRAIN_EXTRA;
  localparam int unsigned CW        = $clog2(N + DRAIN_EXTRA + 1);

  feeder_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  wbuf_q [N];
  logic [W-1:0]  wbuf_d [N];
  logic          s_ready_q, s_ready_d;
  logic          control_q, control_d;
  logic [W-1:0]  wt_arr_q, wt_arr_d;
  logic [W-1:0]  data_arr_q, data_arr_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [W-1:0]  push_row;
  logic          accept;

  assign accept = s_valid && s_ready_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wbuf_d    = wbuf_q;
    err_d     = err_q;
    control_d = 1'b0;
    wt_arr_d  = '0;
    done_d    = 1'b0;
    push_row  = '0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = LOAD_WT;
          cnt_d   = '0;
          err_d   = 1'b0;
        end
      end
      LOAD_WT: begin
        if (accept) begin
          if (s_wt) begin
            for (int unsigned i = 0; i < N; i++) begin
              if (cnt_q == CW'(i)) wbuf_d[i] = s_data;
            end
            if (cnt_q == CW'(N - 1)) begin
              state_d = EMIT_WT;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EMIT_WT: begin
        control_d = 1'b1;
        for (int unsigned i = 0; i < N; i++) begin
          if (cnt_q == CW'(i)) wt_arr_d = wbuf_q[i];
        end
        if (cnt_q == CW'(N - 1)) begin
          state_d = FEED;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      FEED: begin
        // Bubbles and misplaced weight rows both enter the skew as zero rows.
        if (accept) begin
          if (s_wt) err_d = 1'b1;
          else      push_row = s_data;
          if (s_last) begin
            state_d = DRAIN;
            cnt_d   = '0;
          end
        end
      end
      DRAIN: begin
        if (cnt_q == CW'(DRAIN_LEN - 1)) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    s_ready_d = (state_d == LOAD_WT) || (state_d == FEED);
    busy_d    = (state_d != IDLE);
  end

  generate
    for (genvar l = 0; l < N; l++) begin : g_lane
      logic [DW-1:0] lane_out;
      mmu_skew_line #(
        .DEPTH(l),
        .DW   (DW)
      ) u_skew (
        .clk  (clk),
        .rst_n(rst_n),
        .din  (push_row[lane_lsb(l, N, DW) +: DW]),
        .dout (lane_out)
      );
      assign data_arr_d[lane_lsb(l, N, DW) +: DW] = lane_out;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      wbuf_q     <= '{default: '0};
      s_ready_q  <= 1'b0;
      control_q  <= 1'b0;
      wt_arr_q   <= '0;
      data_arr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wbuf_q     <= wbuf_d;
      s_ready_q  <= s_ready_d;
      control_q  <= control_d;
      wt_arr_q   <= wt_arr_d;
      data_arr_q <= data_arr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign s_ready  = s_ready_q;
  assign control  = control_q;
  assign wt_arr   = wt_arr_q;
  assign data_arr = data_arr_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mmu_feeder.sv
// Directed bench for mmu_feeder with N=4, DW=8, DRAIN_EXTRA=4.
module tb_mmu_feeder;

  localparam int unsigned NN     = 4;
  localparam int unsigned DEXTRA = 4;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_wt;
  logic        s_last;
  logic        control;
  logic [31:0] wt_arr;
  logic [31:0] data_arr;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  mmu_feeder #(
    .N          (4),
    .DW         (8),
    .DRAIN_EXTRA(4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .s_wt    (s_wt),
    .s_last  (s_last),
    .control (control),
    .wt_arr  (wt_arr),
    .data_arr(data_arr),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_control"},  {31'd0, control}, 32'd0);
    chk({tag, "_wt_arr"},   wt_arr,           32'd0);
    chk({tag, "_data_arr"}, data_arr,         32'd0);
    chk({tag, "_busy"},     {31'd0, busy},    32'd0);
    chk({tag, "_done"},     {31'd0, done},    32'd0);
    chk({tag, "_err"},      {31'd0, err},     32'd0);
    chk({tag, "_s_ready"},  {31'd0, s_ready}, 32'd0);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_busy",   {31'd0, busy},    32'd1);
    chk("start_sready", {31'd0, s_ready}, 32'd1);
  endtask

  // Loads the four weight rows, then checks the four-cycle control window.
  task automatic load_weights(input bit gaps);
    logic [31:0] w [4];
    w = '{32'h05020304, 32'h03010203, 32'h07040102, 32'h01020403};
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1;
      s_wt    = 1'b1;
      s_data  = w[i];
      step();
      s_valid = 1'b0;
      s_wt    = 1'b0;
      s_data  = '0;
      if (gaps && i < 3) begin
        step();
        chk("gap_control", {31'd0, control}, 32'd0);
      end
    end
    chk("wt_sready_drop", {31'd0, s_ready}, 32'd0);
    chk("wt_ctrl_pre",    {31'd0, control}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("emit_control", {31'd0, control}, 32'd1);
      chk("emit_wt_arr",  wt_arr,           w[i]);
    end
    step();
    chk("emit_end_control", {31'd0, control}, 32'd0);
    chk("emit_end_wt_arr",  wt_arr,           32'd0);
    chk("feed_sready",      {31'd0, s_ready}, 32'd1);
  endtask

  // Streams the four data rows (optionally with one bubble after row 1)
  // and checks the skewed output and the done pulse.
  task automatic feed_and_check(input bit bubble);
    logic [31:0] rows [4];
    logic [31:0] expv [9];
    int nin;
    int done_at;
    int idx;
    int ridx;
    rows = '{32'h01020506, 32'h02030607, 32'h03040708, 32'h04050809};
    if (bubble)
      expv = '{32'h01000000, 32'h00020000, 32'h02000500, 32'h03030006, 32'h04040600,
               32'h00050707, 32'h00000808, 32'h00000009, 32'h00000000};
    else
      expv = '{32'h01000000, 32'h02020000, 32'h03030500, 32'h04040606, 32'h00050707,
               32'h00000808, 32'h00000009, 32'h00000000, 32'h00000000};
    nin     = bubble ? 5 : 4;
    done_at = nin + NN + DEXTRA - 1;
    for (int j = 1; j <= done_at + 1; j++) begin
      idx = j - 1;
      s_wt = 1'b0;
      if (idx < nin && !(bubble && idx == 1)) begin
        ridx    = (bubble && idx > 1) ? idx - 1 : idx;
        s_valid = 1'b1;
        s_data  = rows[ridx];
        s_last  = (idx == nin - 1);
      end else begin
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
      end
      step();
      if (j <= 9) chk(bubble ? "bubble_data_arr" : "skew_data_arr", data_arr, expv[j-1]);
      chk("done_pulse", {31'd0, done}, (j == done_at) ? 32'd1 : 32'd0);
      if (j == nin) chk("drain_sready", {31'd0, s_ready}, 32'd0);
      if (j == done_at - 1) chk("drain_busy", {31'd0, busy}, 32'd1);
      if (j == done_at) chk("done_busy", {31'd0, busy}, 32'd0);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = '0;
    s_wt    = 1'b0;
    s_last  = 1'b0;

    // Reset
    #1;
    chk_all_zero("in_reset");
    step();
    step();
    step();
    rst_n = 1'b1;
    step();
    chk_all_zero("post_reset");
    s_valid = 1'b1;
    s_data  = 32'h11223344;
    step();
    chk("idle_sready", {31'd0, s_ready}, 32'd0);
    chk("idle_busy",   {31'd0, busy},    32'd0);
    s_valid = 1'b0;
    s_data  = '0;

    // Job 1: gapped weight load, back-to-back data
    do_start();
    load_weights(1'b1);
    feed_and_check(1'b0);
    chk("job1_err", {31'd0, err}, 32'd0);

    // Job 2: data row in LOAD_WT, ignored start, bubble in FEED
    do_start();
    chk("job2_err_clear", {31'd0, err}, 32'd0);
    s_valid = 1'b1;
    s_wt    = 1'b0;
    s_data  = 32'hAABBCCDD;
    step();
    s_valid = 1'b0;
    s_data  = '0;
    chk("load_data_err",    {31'd0, err},     32'd1);
    chk("load_err_sready",  {31'd0, s_ready}, 32'd1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("busy_start_err",  {31'd0, err},  32'd1);
    chk("busy_start_busy", {31'd0, busy}, 32'd1);
    load_weights(1'b0);
    feed_and_check(1'b1);
    chk("job2_err_sticky", {31'd0, err}, 32'd1);

    // Job 3: weight row in FEED, then reset after two data rows
    do_start();
    chk("job3_err_clear", {31'd0, err}, 32'd0);
    load_weights(1'b0);
    s_valid = 1'b1;
    s_wt    = 1'b1;
    s_data  = 32'hFFFFFFFF;
    step();
    chk("feed_wt_err",  {31'd0, err}, 32'd1);
    chk("feed_wt_zero", data_arr,     32'd0);
    s_wt   = 1'b0;
    s_data = 32'h01020506;
    step();
    chk("mid_row1", data_arr, 32'h01000000);
    s_data = 32'h02030607;
    step();
    chk("mid_row2", data_arr, 32'h02020000);
    s_valid = 1'b0;
    s_data  = '0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("post_abort_done", {31'd0, done}, 32'd0);
    end
    chk("post_abort_busy", {31'd0, busy}, 32'd0);

    // Job 4: full clean job after the abort
    do_start();
    load_weights(1'b1);
    feed_and_check(1'b0);
    chk("job4_err", {31'd0, err}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
